// File: rtl/frame_pkg.sv
// Shared types and CRC helper for the frame receive parser.
// crc16_word folds one 16-bit word MSB first, so it matches byte-wise CRC-16/XMODEM.
package frame_pkg;

   localparam int          WORD_W   = 16;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      HDR2 = 2'd1,
      CHAN = 2'd2,
      BODY = 2'd3
   } state_e;

   function automatic logic [WORD_W-1:0] crc16_word(input logic [WORD_W-1:0] crc,
                                                    input logic [WORD_W-1:0] word);
      logic [WORD_W-1:0] c;
      c = crc;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (c[WORD_W-1] ^ word[i]) begin
            c = {c[WORD_W-2:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[WORD_W-2:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/frame_rx_parser_if.sv
// Word stream in, parallel frame record out; master is the parser side.
interface frame_rx_parser_if #(
   parameter int MAX_WORDS = 8,
   parameter int NUM_CH    = 8
);
   import frame_pkg::*;

   localparam int LEN_W = $clog2(MAX_WORDS + 1);

   logic [WORD_W-1:0]           data_in;
   logic                        in_vld;
   logic [WORD_W*MAX_WORDS-1:0] out_data;
   logic [LEN_W-1:0]            out_len;
   logic [NUM_CH-1:0]           out_chan;
   logic                        out_vld;
   logic                        out_ready;
   logic                        crc_ok;
   logic                        crc_err;
   logic                        fmt_err;
   logic                        ovf;

   modport master (
      input  data_in, in_vld, out_ready,
      output out_data, out_len, out_chan, out_vld, crc_ok, crc_err, fmt_err, ovf
   );

   modport slave (
      output data_in, in_vld, out_ready,
      input  out_data, out_len, out_chan, out_vld, crc_ok, crc_err, fmt_err, ovf
   );

endinterface

// File: rtl/frame_payload_buf.sv
// Payload shift buffer: newest word enters at [15:0], older words move up.
// Cleared at frame start so words above the payload read as zero.
module frame_payload_buf
   import frame_pkg::*;
#(
   parameter int MAX_WORDS = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clr_i,
   input  logic                        push_i,
   input  logic [WORD_W-1:0]           word_i,
   output logic [WORD_W*MAX_WORDS-1:0] data_o
);

   logic [WORD_W*MAX_WORDS-1:0] data_q;
   logic [WORD_W*MAX_WORDS-1:0] data_d;
   logic [WORD_W*MAX_WORDS-1:0] shifted_s;

   generate
      if (MAX_WORDS == 1) begin : g_single
         assign shifted_s = word_i;
      end else begin : g_multi
         assign shifted_s = {data_q[WORD_W*(MAX_WORDS-1)-1:0], word_i};
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (push_i) begin
         data_d = shifted_s;
      end else begin
         data_d = data_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/frame_rx_parser.sv
// Frame receive parser: header hunt, one-hot channel, payload capture, CRC-16 check,
// trailer detection and a valid/ready record output with overflow reporting.
module frame_rx_parser
   import frame_pkg::*;
#(
   parameter int          MAX_WORDS = 8,
   parameter int          NUM_CH    = 8,
   parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
   parameter logic [31:0] TRAILER   = 32'h0E0E0E0E
) (
   input  logic             clk_in,
   input  logic             rst_n,
   frame_rx_parser_if.master bus
);

   localparam int               LEN_W     = $clog2(MAX_WORDS + 1);
   localparam int               CNT_W     = $clog2(MAX_WORDS + 4);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WORDS + 2);

   state_e                      state_q;
   logic [WORD_W-1:0]           d1_q;
   logic [WORD_W-1:0]           d2_q;
   logic                        d1_vld_q;
   logic                        d2_vld_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [CNT_W-1:0]            cnt_d;
   logic [WORD_W-1:0]           crc_q;
   logic [WORD_W-1:0]           crc_d;
   logic [NUM_CH-1:0]           chan_q;

   logic [WORD_W*MAX_WORDS-1:0] out_data_q;
   logic [LEN_W-1:0]            out_len_q;
   logic [NUM_CH-1:0]           out_chan_q;
   logic                        out_vld_q;
   logic                        crc_ok_q;
   logic                        crc_err_q;
   logic                        fmt_err_q;
   logic                        ovf_q;

   logic [WORD_W-1:0]           word_s;
   logic                        chan_ok_s;
   logic                        is_end_s;
   logic                        buf_clr_s;
   logic                        buf_push_s;
   logic [WORD_W*MAX_WORDS-1:0] buf_data_s;
   logic [LEN_W-1:0]            frame_len_s;

   assign word_s    = bus.data_in;
   assign chan_ok_s = $onehot(word_s[NUM_CH-1:0]) && ((word_s >> NUM_CH) == '0);
   assign is_end_s  = (state_q == BODY) && (word_s == TRAILER[15:0]) &&
                      d1_vld_q && (d1_q == TRAILER[31:16]);

   assign cnt_d       = cnt_q + CNT_W'(1);
   assign crc_d       = crc16_word(crc_q, d2_q);
   assign frame_len_s = LEN_W'(cnt_q - CNT_W'(2));

   // The word leaving the delay line is payload only if the frame has not ended here.
   assign buf_clr_s  = bus.in_vld && (state_q == CHAN) && chan_ok_s;
   assign buf_push_s = bus.in_vld && (state_q == BODY) && !is_end_s &&
                       (cnt_d <= CNT_LIMIT) && d2_vld_q;

   frame_payload_buf #(
      .MAX_WORDS(MAX_WORDS)
   ) u_buf (
      .clk_i (clk_in),
      .rst_ni(rst_n),
      .clr_i (buf_clr_s),
      .push_i(buf_push_s),
      .word_i(d2_q),
      .data_o(buf_data_s)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         d1_q       <= '0;
         d2_q       <= '0;
         d1_vld_q   <= 1'b0;
         d2_vld_q   <= 1'b0;
         cnt_q      <= '0;
         crc_q      <= '0;
         chan_q     <= '0;
         out_data_q <= '0;
         out_len_q  <= '0;
         out_chan_q <= '0;
         out_vld_q  <= 1'b0;
         crc_ok_q   <= 1'b0;
         crc_err_q  <= 1'b0;
         fmt_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         crc_ok_q  <= 1'b0;
         crc_err_q <= 1'b0;
         fmt_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         if (out_vld_q && bus.out_ready) begin
            out_vld_q <= 1'b0;
         end
         if (bus.in_vld) begin
            case (state_q)
               HUNT: begin
                  if (word_s == HEADER[31:16]) begin
                     state_q <= HDR2;
                  end
               end
               HDR2: begin
                  if (word_s == HEADER[15:0]) begin
                     state_q <= CHAN;
                  end else if (word_s == HEADER[31:16]) begin
                     state_q <= HDR2;
                  end else begin
                     state_q <= HUNT;
                  end
               end
               CHAN: begin
                  if (chan_ok_s) begin
                     state_q  <= BODY;
                     chan_q   <= word_s[NUM_CH-1:0];
                     crc_q    <= '0;
                     cnt_q    <= '0;
                     d1_vld_q <= 1'b0;
                     d2_vld_q <= 1'b0;
                  end else begin
                     fmt_err_q <= 1'b1;
                     state_q   <= HUNT;
                  end
               end
               BODY: begin
                  if (is_end_s) begin
                     state_q <= HUNT;
                     if (cnt_q < CNT_W'(3)) begin
                        fmt_err_q <= 1'b1;
                     end else if (crc_q != d2_q) begin
                        crc_err_q <= 1'b1;
                     end else begin
                        crc_ok_q <= 1'b1;
                        // A record accepted this very cycle frees the slot for the new one.
                        if (!out_vld_q || bus.out_ready) begin
                           out_data_q <= buf_data_s;
                           out_len_q  <= frame_len_s;
                           out_chan_q <= chan_q;
                           out_vld_q  <= 1'b1;
                        end else begin
                           ovf_q <= 1'b1;
                        end
                     end
                  end else if (cnt_d > CNT_LIMIT) begin
                     fmt_err_q <= 1'b1;
                     state_q   <= HUNT;
                  end else begin
                     if (d2_vld_q) begin
                        crc_q <= crc_d;
                     end
                     d2_q     <= d1_q;
                     d2_vld_q <= d1_vld_q;
                     d1_q     <= word_s;
                     d1_vld_q <= 1'b1;
                     cnt_q    <= cnt_d;
                  end
               end
               default: begin
                  state_q <= HUNT;
               end
            endcase
         end
      end
   end

   assign bus.out_data = out_data_q;
   assign bus.out_len  = out_len_q;
   assign bus.out_chan = out_chan_q;
   assign bus.out_vld  = out_vld_q;
   assign bus.crc_ok   = crc_ok_q;
   assign bus.crc_err  = crc_err_q;
   assign bus.fmt_err  = fmt_err_q;
   assign bus.ovf      = ovf_q;

endmodule
